pin_roll_tracker: RTL

PIN_ROLL_TRACKER -- requirements
Module: pin_roll_tracker

---
 rtl/pin_roll_tracker_if.sv | 39 +++
 rtl/pin_roll_tracker.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pin_roll_tracker_if.sv
// -----------------------------------------------------------------------------
// pin_roll_tracker_if
// Purpose : groups the roll-control, pin-sense and result signals exchanged
//           between the bowling-lane physics/scorer side and pin_roll_tracker.
// Signals : roll_start_in   1  pulse, ball released
//           ball_done_in    1  pulse, ball reached pit/gutter end
//           knock_in       10  per-pin displaced level from physics
//           valid_out       1  pulse, roll result available
//           pin_hit_out    10  pins newly knocked this roll (0 unless valid_out)
//           standing_out   10  mask of pins currently standing
//           chance_out      1  0 = first ball of frame, 1 = second
//           rack_reset_out  1  pulse, re-rack all pins
//           busy_out        1  tracker not idle
// Modports: master = environment (drives the *_in signals)
//           slave  = tracker     (drives the *_out signals)
// -----------------------------------------------------------------------------
interface pin_roll_tracker_if;
   logic       roll_start_in;
   logic       ball_done_in;
   logic [9:0] knock_in;
   logic       valid_out;
   logic [9:0] pin_hit_out;
   logic [9:0] standing_out;
   logic       chance_out;
   logic       rack_reset_out;
   logic       busy_out;

   modport master (
      output roll_start_in, ball_done_in, knock_in,
      input  valid_out, pin_hit_out, standing_out, chance_out,
             rack_reset_out, busy_out
   );

   modport slave (
      input  roll_start_in, ball_done_in, knock_in,
      output valid_out, pin_hit_out, standing_out, chance_out,
             rack_reset_out, busy_out
   );
endinterface

// File: rtl/pin_roll_tracker.sv
// -----------------------------------------------------------------------------
// pin_roll_tracker
// Purpose : tracks which pins fall during one ball of a bowling frame, waits a
//           settle window for late falls, reports the newly knocked pins to the
//           scorer, and requests a re-rack at the end of each frame.
// Ports   : clk_in    - system clock, all state on rising edge
//           rst_n_in  - asynchronous active-low reset
//           bus       - pin_roll_tracker_if.slave (see interface file)
// Params  : SETTLE_CYCLES - cycles after ball_done_in during which late pin
//                           falls are still counted (1..65535)
// Macro   : PIN_DEBOUNCE_EN - when defined, a knock_in bit counts only if it
//                             is high in the current and the previous cycle.
// -----------------------------------------------------------------------------
module pin_roll_tracker #(
   parameter int SETTLE_CYCLES = 1024
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   pin_roll_tracker_if.slave    bus
);

   localparam int CW = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ROLL,
      ST_SETTLE,
      ST_REPORT,
      ST_FILL,
      ST_RACK
   } state_t;

   state_t        state_q,    state_d;
   logic [CW-1:0] cnt_q,      cnt_d;
   logic [9:0]    hit_q,      hit_d;
   logic [9:0]    standing_q, standing_d;
   logic          chance_q,   chance_d;
   logic          valid_q,    valid_d;
   logic [9:0]    pin_hit_q,  pin_hit_d;
   logic          rack_q,     rack_d;

   logic [9:0]    knock_eff;
   logic [9:0]    hit_acc;
   logic [9:0]    standing_left;

`ifdef PIN_DEBOUNCE_EN
   // One sample stage: a bit must be seen in two consecutive cycles.
   logic [9:0]    knock_prev_q, knock_prev_d;
   assign knock_prev_d = bus.knock_in;
   assign knock_eff    = bus.knock_in & knock_prev_q;
`else
   assign knock_eff    = bus.knock_in;
`endif

   // Only pins still standing can be newly hit, so a roll can never report
   // more pins than were up before it.
   assign hit_acc       = hit_q | (knock_eff & standing_q);
   assign standing_left = standing_q & ~hit_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hit_d      = hit_q;
      standing_d = standing_q;
      chance_d   = chance_q;
      valid_d    = 1'b0;
      pin_hit_d  = 10'h000;
      rack_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // ball_done_in in the same cycle is deliberately dropped.
            if (bus.roll_start_in) state_d = ST_ROLL;
         end
         ST_ROLL: begin
            hit_d = hit_acc;
            if (bus.ball_done_in) begin
               state_d = ST_SETTLE;
               cnt_d   = CW'(SETTLE_CYCLES);
            end
         end
         ST_SETTLE: begin
            hit_d = hit_acc;
            if (cnt_q == CW'(1)) begin
               // Outputs are registered, so load them as REPORT is entered,
               // including any fall seen in this last settle cycle.
               state_d   = ST_REPORT;
               cnt_d     = '0;
               valid_d   = 1'b1;
               pin_hit_d = hit_acc;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_REPORT: begin
            standing_d = standing_left;
            hit_d      = 10'h000;
            if (chance_q) begin
               state_d = ST_RACK;
               rack_d  = 1'b1;
            end else if (standing_left == 10'h000) begin
               // Strike: emit an empty second result so every frame has two.
               state_d = ST_FILL;
               valid_d = 1'b1;
            end else begin
               state_d  = ST_IDLE;
               chance_d = 1'b1;
            end
         end
         ST_FILL: begin
            state_d = ST_RACK;
            rack_d  = 1'b1;
         end
         ST_RACK: begin
            standing_d = 10'h3FF;
            chance_d   = 1'b0;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         hit_q        <= 10'h000;
         standing_q   <= 10'h3FF;
         chance_q     <= 1'b0;
         valid_q      <= 1'b0;
         pin_hit_q    <= 10'h000;
         rack_q       <= 1'b0;
`ifdef PIN_DEBOUNCE_EN
         knock_prev_q <= 10'h000;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hit_q        <= hit_d;
         standing_q   <= standing_d;
         chance_q     <= chance_d;
         valid_q      <= valid_d;
         pin_hit_q    <= pin_hit_d;
         rack_q       <= rack_d;
`ifdef PIN_DEBOUNCE_EN
         knock_prev_q <= knock_prev_d;
`endif
      end
   end

   assign bus.valid_out      = valid_q;
   assign bus.pin_hit_out    = pin_hit_q;
   assign bus.standing_out   = standing_q;
   assign bus.chance_out     = chance_q;
   assign bus.rack_reset_out = rack_q;
   assign bus.busy_out       = (state_q != ST_IDLE);

endmodule
